// File: rtl/sdram_frame_reader_if.sv
// ---------------------------------------------------------------------------
// sdram_frame_reader_if
// Bundles the frame trigger, SDRAM burst-read handshake, display FIFO write
// side and status flags of sdram_frame_reader.
//   master : the frame reader (drives rd_req/rd_addr, FIFO write, status)
//   slave  : the environment (SDRAM controller, display FIFO, top level)
// Signals:
//   frame_start   1-cycle pulse: start reading one frame
//   rd_req        burst read request          rd_addr  24-bit burst word address
//   rd_ack        request accepted            rd_valid returned word strobe
//   rd_data       16-bit RGB565 word          fifo_wrusedw 12-bit FIFO fill
//   fifo_wrfull   FIFO full                   wr_fifo  FIFO write strobe
//   fifo_data     FIFO write data             busy     frame in progress
//   frame_done    1-cycle end-of-frame pulse  overflow sticky overflow flag
// ---------------------------------------------------------------------------
interface sdram_frame_reader_if;
    logic        frame_start;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [11:0] fifo_wrusedw;
    logic        fifo_wrfull;
    logic        wr_fifo;
    logic [15:0] fifo_data;
    logic        busy;
    logic        frame_done;
    logic        overflow;

    modport master (
        input  frame_start, rd_ack, rd_valid, rd_data, fifo_wrusedw, fifo_wrfull,
        output rd_req, rd_addr, wr_fifo, fifo_data, busy, frame_done, overflow
    );

    modport slave (
        output frame_start, rd_ack, rd_valid, rd_data, fifo_wrusedw, fifo_wrfull,
        input  rd_req, rd_addr, wr_fifo, fifo_data, busy, frame_done, overflow
    );
endinterface

// File: rtl/sdram_frame_reader.sv
// ---------------------------------------------------------------------------
// sdram_frame_reader
// Reads one RGB565 frame from SDRAM in fixed-size bursts and writes every
// returned word into the display FIFO. Requests are throttled so that the
// words already in the FIFO plus the words still in flight never exceed the
// FIFO depth.
// Ports:
//   clk_sdram  SDRAM/system clock, all logic on its rising edge
//   rst        synchronous active-high reset
//   bus        sdram_frame_reader_if.master (handshake, FIFO write, status)
// ---------------------------------------------------------------------------
module sdram_frame_reader #(
    parameter int          H_RES      = 320,
    parameter int          V_RES      = 240,
    parameter int          BURST      = 8,
    parameter int          FIFO_DEPTH = 4096,
    parameter logic [23:0] BASE_ADDR  = 24'd0
) (
    input  logic                        clk_sdram,
    input  logic                        rst,
    sdram_frame_reader_if.master        bus
);

    localparam int TOTAL_WORDS  = H_RES * V_RES;
    localparam int TOTAL_BURSTS = TOTAL_WORDS / BURST;
    localparam int XW = $clog2(H_RES + 1);
    localparam int YW = $clog2(V_RES + 1);
    localparam int WW = $clog2(TOTAL_WORDS + 1);
    localparam int BW = $clog2(TOTAL_BURSTS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    if (((H_RES % BURST) != 0) || (BURST > 64) || ((BURST & (BURST - 1)) != 0))
    begin : g_param_check
        $error("sdram_frame_reader: BURST must be a power of 2 <= 64 dividing H_RES");
    end

    logic [2:0]    r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [BW-1:0] r_bursts;
    logic [WW-1:0] r_words;
    logic [12:0]   r_outstanding;
    logic          r_rd_req;
    logic [23:0]   r_rd_addr;
    logic          r_vld_p1;
    logic [15:0]   r_data_p1;
    logic          r_busy;
    logic          r_frame_done;
    logic          r_overflow;

    logic [13:0]   w_free;
    logic          w_room;
    logic          w_all_issued;
    logic          w_beat;
    logic          w_ack;
    logic [23:0]   w_addr;

    // One spare bit on top of the 13-bit free count so a transient negative
    // value (FIFO level lagging the in-flight count) reads as "no room".
    assign w_free       = 14'(FIFO_DEPTH) - {2'b00, bus.fifo_wrusedw} - {1'b0, r_outstanding};
    assign w_room       = !w_free[13] && (w_free >= 14'(BURST));
    assign w_all_issued = (r_bursts == BW'(TOTAL_BURSTS));
    assign w_beat       = bus.rd_valid && (r_state != S_IDLE);
    assign w_ack        = (r_state == S_REQ) && bus.rd_ack;
    assign w_addr       = BASE_ADDR + 24'(r_y) * 24'(H_RES) + 24'(r_x);

    always_ff @(posedge clk_sdram) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_bursts      <= '0;
            r_words       <= '0;
            r_outstanding <= '0;
            r_rd_req      <= 1'b0;
            r_rd_addr     <= '0;
            r_vld_p1      <= 1'b0;
            r_data_p1     <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            // ---- stage p1: returned word to FIFO write port ----
            r_vld_p1     <= w_beat;
            r_frame_done <= 1'b0;
            if (w_beat) begin
                r_data_p1 <= bus.rd_data;
                r_words   <= r_words + WW'(1);
                if (bus.fifo_wrfull) begin
                    r_overflow <= 1'b1;
                end
            end

            // Ack and data beat in the same cycle net to +BURST-1.
            r_outstanding <= r_outstanding + (w_ack ? 13'(BURST) : 13'd0)
                                           - (w_beat ? 13'd1 : 13'd0);

            case (r_state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        r_x           <= '0;
                        r_y           <= '0;
                        r_bursts      <= '0;
                        r_words       <= '0;
                        r_outstanding <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_all_issued) begin
                        r_state <= S_DRAIN;
                    end else if (w_room) begin
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= w_addr;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.rd_ack) begin
                        r_rd_req <= 1'b0;
                        r_bursts <= r_bursts + BW'(1);
                        // y ends at V_RES after the last burst of the frame.
                        if (r_x == XW'(H_RES - BURST)) begin
                            r_x <= '0;
                            r_y <= r_y + YW'(1);
                        end else begin
                            r_x <= r_x + XW'(BURST);
                        end
                        r_state <= S_CHECK;
                    end
                end
                S_DRAIN: begin
                    if (r_words == WW'(TOTAL_WORDS)) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_req     = r_rd_req;
    assign bus.rd_addr    = r_rd_addr;
    assign bus.wr_fifo    = r_vld_p1;
    assign bus.fifo_data  = r_data_p1;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_sdram_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_sdram_frame_reader
// Drives sdram_frame_reader with a small frame, a behavioural SDRAM
// controller (random ack delay, 3-cycle read latency, random data gaps) and a
// scoreboard of returned words that must reach the FIFO exactly one cycle
// after they were presented.
// ---------------------------------------------------------------------------
module tb_sdram_frame_reader;

    localparam int          H_RES      = 32;
    localparam int          V_RES      = 6;
    localparam int          BURST      = 8;
    localparam int          FIFO_DEPTH = 4096;
    localparam logic [23:0] BASE       = 24'hFFFF90;
    localparam int          TOTAL      = H_RES * V_RES;
    localparam int          NB         = TOTAL / BURST;

    typedef struct {
        logic [15:0] d;
        int          t;
    } exp_t;

    logic clk_sdram = 1'b0;
    logic rst       = 1'b1;
    always #5 clk_sdram = ~clk_sdram;

    sdram_frame_reader_if bus();

    sdram_frame_reader #(
        .H_RES(H_RES), .V_RES(V_RES), .BURST(BURST),
        .FIFO_DEPTH(FIFO_DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk_sdram(clk_sdram),
        .rst(rst),
        .bus(bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   bq[$];
    int   beat = 0;
    int   ack_wait = 0;
    int   issued = 0, issued_base = 0;
    int   wr_cnt = 0, wr_base = 0;
    int   fd_cnt = 0, fd_base = 0;
    int   req_cnt = 0, req_base = 0;
    int   words_sent = 0;
    int   full_at = -1;
    bit   accepting = 1'b1;
    bit   data_mode = 1'b1;
    logic [15:0] data_ctr = 16'h0000;
    bit   ovf_at_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input logic [31:0] val);
        total++;
        bad++;
        $display("FAIL %s: value %0h (cycle %0d)", name, val, cyc);
    endtask

    always @(posedge clk_sdram) cyc <= cyc + 1;

    // Monitor, scoreboard and SDRAM controller model
    always @(negedge clk_sdram) begin
        if (rst) exp_q.delete();
        while (exp_q.size() > 0 && exp_q[0].t < cyc - 1) begin
            mon_e = exp_q.pop_front();
            fail_evt("wr_missing", {16'h0, mon_e.d});
        end
        if (bus.wr_fifo) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                fail_evt("wr_unexpected", {16'h0, bus.fifo_data});
            end else begin
                mon_e = exp_q.pop_front();
                chk("fifo_data", {16'h0, bus.fifo_data}, {16'h0, mon_e.d});
                chk("wr_latency", cyc - 1, mon_e.t);
            end
        end
        if (bus.frame_done) fd_cnt++;
        if (bus.rd_req) req_cnt++;

        if (bus.rd_ack === 1'b1) begin
            bus.rd_ack = 1'b0;
        end else begin
            bus.rd_ack = 1'b0;
            if (bus.rd_req) begin
                chk("rd_addr", {8'h0, bus.rd_addr}, {8'h0, BASE + 24'((issued - issued_base) * BURST)});
                if (ack_wait > 0) begin
                    ack_wait--;
                end else begin
                    if (issued - issued_base >= NB) fail_evt("extra_req", issued - issued_base);
                    bus.rd_ack = 1'b1;
                    issued++;
                    bq.push_back(cyc + 3);
                    ack_wait = $urandom_range(0, 2);
                end
            end
        end

        bus.rd_valid    = 1'b0;
        bus.fifo_wrfull = 1'b0;
        if (bq.size() > 0 && cyc >= bq[0] && $urandom_range(0, 3) != 0) begin
            bus.rd_valid = 1'b1;
            if (data_mode) begin
                bus.rd_data = data_ctr;
                data_ctr++;
            end else begin
                bus.rd_data = 16'($urandom);
            end
            if (words_sent == full_at) bus.fifo_wrfull = 1'b1;
            words_sent++;
            if (accepting) begin
                mon_e.d = bus.rd_data;
                mon_e.t = cyc;
                exp_q.push_back(mon_e);
            end
            beat++;
            if (beat == BURST) begin
                beat = 0;
                void'(bq.pop_front());
            end
        end
    end

    task automatic step;
        @(negedge clk_sdram);
        #1;
    endtask

    task automatic start_frame;
        issued_base = issued;
        wr_base     = wr_cnt;
        fd_base     = fd_cnt;
        req_base    = req_cnt;
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
    endtask

    task automatic finish_frame(input bit pulse_in_done);
        bit seen = 1'b0;
        for (int n = 0; n < 5000 && !seen; n++) begin
            step();
            if (bus.frame_done) seen = 1'b1;
        end
        chk("frame_done_seen", seen, 1);
        if (seen) begin
            ovf_at_done = bus.overflow;
            chk("words_written", wr_cnt - wr_base, TOTAL);
            chk("bursts_issued", issued - issued_base, NB);
            chk("scoreboard_empty", exp_q.size(), 0);
            if (pulse_in_done) bus.frame_start = 1'b1;
            step();
            bus.frame_start = 1'b0;
            chk("frame_done_pulse", bus.frame_done, 0);
            chk("busy_after_done", bus.busy, 0);
            chk("one_frame_done", fd_cnt - fd_base, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale_base;
        int rb;
        int fb;
        bus.frame_start  = 1'b0;
        bus.fifo_wrusedw = 12'd0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_rd_req",     bus.rd_req, 0);
        chk("rst_rd_addr",    bus.rd_addr, 0);
        chk("rst_wr_fifo",    bus.wr_fifo, 0);
        chk("rst_fifo_data",  bus.fifo_data, 0);
        chk("rst_busy",       bus.busy, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_overflow",   bus.overflow, 0);

        // Full frame, incrementing data across line wraps
        data_mode = 1'b1;
        start_frame();
        finish_frame(1'b0);

        // Throttling: FIFO nearly full, then room appears
        bus.fifo_wrusedw = 12'd4090;
        start_frame();
        repeat (20) step();
        chk("throttle_no_req", req_cnt - req_base, 0);
        bus.fifo_wrusedw = 12'd4000;
        step();
        chk("req_after_room", bus.rd_req, 1);
        repeat (30) step();
        bus.fifo_wrusedw = 12'd0;
        finish_frame(1'b0);

        // Overflow is sticky until reset
        data_mode = 1'b0;
        chk("ovf_clear_before", bus.overflow, 0);
        start_frame();
        full_at = words_sent + 30;
        finish_frame(1'b0);
        chk("ovf_at_done", ovf_at_done, 1);
        repeat (5) step();
        chk("ovf_sticky", bus.overflow, 1);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("ovf_cleared_by_rst", bus.overflow, 0);

        // Reset mid-frame with bursts in flight
        start_frame();
        for (int n = 0; n < 3000 && (wr_cnt - wr_base) < 100; n++) step();
        chk("midframe_progress", (wr_cnt - wr_base) >= 100, 1);
        rst        = 1'b1;
        accepting  = 1'b0;
        stale_base = wr_cnt;
        repeat (2) step();
        rst = 1'b0;
        for (int n = 0; n < 2000 && bq.size() > 0; n++) step();
        repeat (5) step();
        chk("stale_writes", wr_cnt - stale_base, 0);
        chk("busy_after_abort", bus.busy, 0);
        chk("req_after_abort", bus.rd_req, 0);
        accepting = 1'b1;
        start_frame();
        finish_frame(1'b0);

        // frame_start mid-frame and in the DONE cycle are ignored
        start_frame();
        repeat (40) step();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        finish_frame(1'b1);
        rb = req_cnt;
        fb = fd_cnt;
        repeat (40) step();
        chk("no_restart_req", req_cnt - rb, 0);
        chk("no_extra_done", fd_cnt - fb, 0);
        chk("idle_after_done_pulse", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
